// File: rtl/reg_arbiter.sv
// Round-robin arbiter granting N register masters access to one shared
// register slave. One transaction is outstanding at a time: IDLE arbitrates,
// REQ forwards the granted request, RESP forwards the matching response.
module reg_arbiter #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  // master request side
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
  input  logic [NUM_MASTERS-1:0]            m_write,
  input  logic [NUM_MASTERS-1:0]            m_valid,
  output logic [NUM_MASTERS-1:0]            m_ready,
  // master response side
  output logic [DATA_WIDTH-1:0]             m_bdata,
  output logic [DATA_WIDTH-1:0]             m_rdata,
  output logic [NUM_MASTERS-1:0]            m_bvalid,
  output logic [NUM_MASTERS-1:0]            m_rvalid,
  input  logic [NUM_MASTERS-1:0]            m_bready,
  input  logic [NUM_MASTERS-1:0]            m_rready,
  // slave request channel
  output logic [ADDR_WIDTH-1:0]             s_addr,
  output logic [DATA_WIDTH-1:0]             s_wdata,
  output logic                              s_write,
  output logic                              s_valid,
  input  logic                              s_ready,
  // slave response channels
  input  logic [DATA_WIDTH-1:0]             s_bdata,
  input  logic                              s_bvalid,
  output logic                              s_bready,
  input  logic [DATA_WIDTH-1:0]             s_rdata,
  input  logic                              s_rvalid,
  output logic                              s_rready,
  // status
  output logic [NUM_MASTERS-1:0]            grant,
  output logic                              busy
);

  localparam int unsigned IDX_W = $clog2(NUM_MASTERS);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_e;

  state_e                   state_q;
  logic [NUM_MASTERS-1:0]   grant_q;
  logic [IDX_W-1:0]         gidx_q;
  logic [IDX_W-1:0]         last_q;
  logic                     wr_q;
  logic                     busy_q;

  logic                     found;
  logic [IDX_W-1:0]         rr_idx;
  logic [IDX_W-1:0]         cand;
  logic                     resp_done;

  logic [ADDR_WIDTH-1:0]    addr_a  [NUM_MASTERS];
  logic [DATA_WIDTH-1:0]    wdata_a [NUM_MASTERS];

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
    assign addr_a[gi]  = m_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[gi] = m_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin pick: first valid master scanning from last_q+1 with wrap.
  always_comb begin
    found  = 1'b0;
    rr_idx = '0;
    cand   = '0;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      cand = IDX_W'((32'(last_q) + i) % NUM_MASTERS);
      if (!found && m_valid[cand]) begin
        found  = 1'b1;
        rr_idx = cand;
      end
    end
  end

  assign resp_done = wr_q ? (s_bvalid && m_bready[gidx_q])
                          : (s_rvalid && m_rready[gidx_q]);

  // Transaction FSM with registered grant/busy and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IDX_W'(NUM_MASTERS - 1);
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            state_q <= REQ;
            gidx_q  <= rr_idx;
            grant_q <= {{(NUM_MASTERS-1){1'b0}}, 1'b1} << rr_idx;
            busy_q  <= 1'b1;
          end
        end
        REQ: begin
          if (m_valid[gidx_q] && s_ready) begin
            wr_q    <= m_write[gidx_q];
            state_q <= RESP;
          end
        end
        RESP: begin
          if (resp_done) begin
            last_q  <= gidx_q;
            grant_q <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Channel steering: only the granted master is connected, only in its phase.
  always_comb begin
    m_ready  = '0;
    m_bvalid = '0;
    m_rvalid = '0;
    m_bdata  = '0;
    m_rdata  = '0;
    s_addr   = '0;
    s_wdata  = '0;
    s_write  = 1'b0;
    s_valid  = 1'b0;
    s_bready = 1'b0;
    s_rready = 1'b0;
    case (state_q)
      REQ: begin
        s_addr          = addr_a[gidx_q];
        s_wdata         = wdata_a[gidx_q];
        s_write         = m_write[gidx_q];
        s_valid         = m_valid[gidx_q];
        m_ready[gidx_q] = s_ready;
      end
      RESP: begin
        if (wr_q) begin
          m_bvalid[gidx_q] = s_bvalid;
          m_bdata          = s_bdata;
          s_bready         = m_bready[gidx_q];
        end else begin
          m_rvalid[gidx_q] = s_rvalid;
          m_rdata          = s_rdata;
          s_rready         = m_rready[gidx_q];
        end
      end
      default: ;
    endcase
  end

  assign grant = grant_q;
  assign busy  = busy_q;

endmodule

// File: doc/reg_arbiter.md
REG_ARBITER -- requirements
Module: reg_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2, number of requesting register masters (≥2).
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, register address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset; synchronous, active-low.
REQ-006 SHALL have ports m_addr/m_wdata  in  NUM_MASTERS*ADDR_WIDTH / NUM_MASTERS*DATA_WIDTH  packed per-master request payload, master i at slice i.
REQ-007 SHALL have ports m_write, m_valid  in  NUM_MASTERS  per-master write flag and request valid.
REQ-008 SHALL have port m_ready  out  NUM_MASTERS  per-master request accept.
REQ-009 SHALL have ports m_bdata, m_rdata  out  DATA_WIDTH  write-response/read data, shared by all masters.
REQ-010 SHALL have ports m_bvalid, m_rvalid  out  NUM_MASTERS; m_bready, m_rready  in  NUM_MASTERS  per-master response handshakes.
REQ-011 SHALL have ports s_addr out ADDR_WIDTH, s_wdata out DATA_WIDTH, s_write out 1, s_valid out 1, s_ready in 1  shared slave request channel.
REQ-012 SHALL have ports s_bdata in DATA_WIDTH, s_bvalid in 1, s_bready out 1, s_rdata in DATA_WIDTH, s_rvalid in 1, s_rready out 1  slave response channels.
REQ-013 SHALL have ports grant out NUM_MASTERS (one-hot current owner) and busy out 1 (state != IDLE).

Function
REQ-014 SHALL implement FSM states IDLE, REQ, RESP; one transaction outstanding at a time.
REQ-015 IDLE: when any m_valid set, SHALL select winner round-robin starting at (last_grant+1) mod NUM_MASTERS, register grant, go to REQ next edge; no valid -> stay IDLE.
REQ-016 REQ: SHALL drive s_addr/s_wdata/s_write from granted master, s_valid = m_valid[g], m_ready[g] = s_ready, other m_ready bits 0.
REQ-017 On s_valid && s_ready in REQ, SHALL latch transaction type (write/read) and go to RESP.
REQ-018 RESP write: SHALL forward s_bvalid to m_bvalid[g], s_bdata to m_bdata, m_bready[g] to s_bready; s_rready held 0.
REQ-019 RESP read: SHALL forward s_rvalid to m_rvalid[g], s_rdata to m_rdata, m_rready[g] to s_rready; s_bready held 0.
REQ-020 On response handshake of latched type, SHALL set last_grant = g, clear grant, return to IDLE.
REQ-021 Outside REQ, s_valid, s_addr, s_wdata, s_write SHALL be 0; outside RESP, all m_bvalid/m_rvalid, s_bready, s_rready SHALL be 0.
REQ-022 Non-granted masters SHALL see m_ready, m_bvalid, m_rvalid all 0 at all times.
REQ-023 Responses on s_bvalid/s_rvalid SHALL be ignored outside RESP; slave responds no earlier than cycle after request accept.
REQ-024 Masters SHALL hold m_valid and payload until m_ready; arbiter SHALL NOT re-arbitrate while in REQ or RESP, regardless of other requests.
REQ-025 Minimum throughput SHALL be one transaction per 3 cycles (IDLE, REQ, RESP with immediate handshakes).
REQ-026 m_bdata/m_rdata SHALL be combinational pass-through of s_bdata/s_rdata (zero added latency).

Reset
REQ-027 rst_n low at a rising edge SHALL force IDLE, grant=0, busy=0, last_grant=NUM_MASTERS-1 (master 0 first priority) from that edge, including mid-REQ or mid-RESP; in-flight transaction dropped.
REQ-028 During/after reset all outputs SHALL be 0: m_ready, m_bvalid, m_rvalid, m_bdata, m_rdata gated to 0 outside RESP, s_valid, s_addr, s_wdata, s_write, s_bready, s_rready, grant, busy.

Verification
REQ-029 Single write: master 1 addr 0x10 wdata 0xDEADBEEF, slave ready and bvalid immediate -> s_valid cycle+1, grant=0b10, m_bvalid[1] one cycle later, busy low after, 3-cycle total.
REQ-030 Contention: both masters valid continuously after reset -> grants alternate 0,1,0,1 over four transactions.
REQ-031 Backpressure: s_ready low 5 cycles then high, m_rready[0] low 3 cycles during read -> s_addr stable, m_rvalid[0] held, s_rready tracks m_rready[0], m_rdata = s_rdata on handshake.
REQ-032 Wrong-type response: read outstanding, slave pulses s_bvalid -> s_bready stays 0, m_bvalid all 0, FSM remains RESP.
REQ-033 Reset mid-RESP: rst_n low one cycle while waiting bvalid -> next cycle busy=0, grant=0, all valids 0; next request from master 0 and 1 simultaneously grants master 0.
